// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//  Shared definitions for the fetch-PC sequencer of the 32-bit MIPS pipeline:
//  default reset PC, jump offset width, redirect-kind encoding and the
//  sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          OFFS_W_DEF   = 26;

    // Kind of redirect carried with a target (pending register and arbitration)
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_J    = 2'd1,
        REDIR_BR   = 2'd2
    } redir_kind_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_t;

endpackage

// File: rtl/Shift_Concatinate.sv
// ---------------------------------------------------------------------------
// Shift_Concatinate
//  J-format jump-target builder: {pc4[31:OFFS_W+2], offset, 2'b00}.
//  Ports:
//   offset  in   OFFS_W  J-format target field
//   pc4     in   32      PC+4 of the jump (only the upper region is used)
//   target  out  32      word-aligned jump target
// ---------------------------------------------------------------------------
module Shift_Concatinate #(
    parameter int OFFS_W = 26
) (
    input  logic [OFFS_W-1:0] offset,
    input  logic [31:0]       pc4,
    output logic [31:0]       target
);

    // The low bits of pc4 are replaced by the shifted offset and never read.
    logic unused_pc4_s;

    assign target       = {pc4[31:OFFS_W+2], offset, 2'b00};
    assign unused_pc4_s = ^pc4[OFFS_W+1:0];

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//  Owns the fetch PC. Selects PC+4, a jump target or a branch target,
//  arbitrates simultaneous redirects (branch wins, being older), holds a
//  redirect that arrives during a stall and applies it on the first
//  unstalled edge, and emits one-cycle registered flush pulses.
//  Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall_in                 hazard unit: hold PC this cycle
//   jump_valid/offset/pc4    J instruction in ID
//   branch_valid/target      taken branch resolved in EX
//   pc_out, pc_plus4_out     current fetch address and its successor
//   fetch_valid              0 only in BOOT
//   flush_if_id, flush_id_ex squash pulses (branch: both, jump: IF/ID only)
//   redirect_pend            a held redirect waits for the stall to drop
// ---------------------------------------------------------------------------
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          OFFS_W   = OFFS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              jump_valid,
    input  logic [OFFS_W-1:0] jump_offset,
    input  logic [31:0]       jump_pc4,
    input  logic              branch_valid,
    input  logic [31:0]       branch_target,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4_out,
    output logic              fetch_valid,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              redirect_pend
);

    pc_state_t   state_r;
    pc_state_t   state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pend_target_r;
    logic [31:0] pend_target_next_s;
    redir_kind_t pend_kind_r;
    redir_kind_t pend_kind_next_s;
    logic        flush_if_id_r;
    logic        flush_id_ex_r;
    logic        flush_if_id_next_s;
    logic        flush_id_ex_next_s;
    logic [31:0] jump_target_s;
    logic [31:0] merged_target_s;
    redir_kind_t merged_kind_s;

    Shift_Concatinate #(
        .OFFS_W (OFFS_W)
    ) u_jump_target (
        .offset (jump_offset),
        .pc4    (jump_pc4),
        .target (jump_target_s)
    );

    // Merge any pending redirect with this cycle's requests. In RUN the
    // pending kind is always NONE, so the same rules give plain arbitration:
    // a branch always wins; a jump never displaces a pending branch.
    always_comb begin
        merged_kind_s   = pend_kind_r;
        merged_target_s = pend_target_r;
        if (branch_valid) begin
            merged_kind_s   = REDIR_BR;
            merged_target_s = branch_target;
        end else if (jump_valid && (pend_kind_r != REDIR_BR)) begin
            merged_kind_s   = REDIR_J;
            merged_target_s = jump_target_s;
        end else begin
            merged_kind_s   = pend_kind_r;
            merged_target_s = pend_target_r;
        end
    end

    // Next-state, next-PC, pending-register and flush decisions.
    always_comb begin
        state_next_s       = state_r;
        pc_next_s          = pc_r;
        pend_target_next_s = pend_target_r;
        pend_kind_next_s   = pend_kind_r;
        flush_if_id_next_s = 1'b0;
        flush_id_ex_next_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (merged_kind_s == REDIR_NONE) begin
                    // Only reachable in RUN: sequential fetch or stall.
                    if (stall_in) begin
                        pc_next_s = pc_r;
                    end else begin
                        pc_next_s = pc_r + 32'd4;
                    end
                end else if (stall_in) begin
                    // Redirect cannot be applied yet; flushes defer with it.
                    pend_kind_next_s   = merged_kind_s;
                    pend_target_next_s = merged_target_s;
                    state_next_s       = ST_HOLD;
                end else begin
                    pc_next_s          = merged_target_s;
                    pend_kind_next_s   = REDIR_NONE;
                    pend_target_next_s = 32'h0000_0000;
                    state_next_s       = ST_RUN;
                    flush_if_id_next_s = 1'b1;
                    flush_id_ex_next_s = (merged_kind_s == REDIR_BR);
                end
            end
            default: begin
                // Illegal encoding: restart cleanly through BOOT.
                state_next_s       = ST_BOOT;
                pc_next_s          = RESET_PC;
                pend_kind_next_s   = REDIR_NONE;
                pend_target_next_s = 32'h0000_0000;
            end
        endcase
    end

    // State, PC, pending redirect and flush registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_PC;
            pend_target_r <= 32'h0000_0000;
            pend_kind_r   <= REDIR_NONE;
            flush_if_id_r <= 1'b0;
            flush_id_ex_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            pend_target_r <= pend_target_next_s;
            pend_kind_r   <= pend_kind_next_s;
            flush_if_id_r <= flush_if_id_next_s;
            flush_id_ex_r <= flush_id_ex_next_s;
        end
    end

    assign pc_out        = pc_r;
    assign pc_plus4_out  = pc_r + 32'd4;
    assign fetch_valid   = (state_r != ST_BOOT);
    assign redirect_pend = (state_r == ST_HOLD);
    assign flush_if_id   = flush_if_id_r;
    assign flush_id_ex   = flush_id_ex_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//  Self-checking bench: directed scenarios with literal expectations, then a
//  long randomized run compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        jump_valid;
    logic [25:0] jump_offset;
    logic [31:0] jump_pc4;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        fetch_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        redirect_pend;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .jump_valid    (jump_valid),
        .jump_offset   (jump_offset),
        .jump_pc4      (jump_pc4),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .pc_plus4_out  (pc_plus4_out),
        .fetch_valid   (fetch_valid),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .redirect_pend (redirect_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pending: 0 = nothing held, 1 = jump held, 2 = branch held
    logic [31:0] m_pc;
    logic        m_booting;
    int          m_pend;
    logic [31:0] m_pend_tgt;
    logic        m_fl_ifid;
    logic        m_fl_idex;

    always @(posedge clk or posedge rst) begin : model
        int          k;
        logic [31:0] t;
        if (rst) begin
            m_pc       <= 32'h0;
            m_booting  <= 1'b1;
            m_pend     <= 0;
            m_pend_tgt <= 32'h0;
            m_fl_ifid  <= 1'b0;
            m_fl_idex  <= 1'b0;
        end else if (m_booting) begin
            m_booting <= 1'b0;
        end else begin
            k = m_pend;
            t = m_pend_tgt;
            if (branch_valid) begin
                k = 2;
                t = branch_target;
            end else if (jump_valid && k != 2) begin
                k = 1;
                t = (jump_pc4 & 32'hF000_0000) | ({6'd0, jump_offset} << 2);
            end
            m_fl_ifid <= 1'b0;
            m_fl_idex <= 1'b0;
            if (k == 0) begin
                m_pc <= stall_in ? m_pc : m_pc + 32'd4;
            end else if (stall_in) begin
                m_pend     <= k;
                m_pend_tgt <= t;
            end else begin
                m_pc      <= t;
                m_pend    <= 0;
                m_fl_ifid <= 1'b1;
                m_fl_idex <= (k == 2);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("pc_out",        pc_out,        m_pc);
        chk("pc_plus4_out",  pc_plus4_out,  m_pc + 32'd4);
        chk("fetch_valid",   {31'd0, fetch_valid},   {31'd0, ~m_booting});
        chk("flush_if_id",   {31'd0, flush_if_id},   {31'd0, m_fl_ifid});
        chk("flush_id_ex",   {31'd0, flush_id_ex},   {31'd0, m_fl_idex});
        chk("redirect_pend", {31'd0, redirect_pend}, {31'd0, (m_pend != 0)});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_in      = 1'b0;
        jump_valid    = 1'b0;
        jump_offset   = 26'd0;
        jump_pc4      = 32'h0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
    endtask

    task automatic do_branch(input logic [31:0] tgt);
        branch_valid  = 1'b1;
        branch_target = tgt;
        tick();
        branch_valid  = 1'b0;
    endtask

    task automatic release_and_boot();
        rst = 1'b0;
        chk("boot_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("boot_pc0", pc_out, 32'h0);
        chk("boot_fv1", {31'd0, fetch_valid}, 32'd1);
        tick();
        chk("boot_pc4", pc_out, 32'h4);
        tick();
        chk("boot_pc8", pc_out, 32'h8);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        chk("rst_pend", {31'd0, redirect_pend}, 32'd0);
        release_and_boot();

        // 1: asynchronous reset mid-run at pc 0x40
        for (int i = 0; i < 20 && pc_out != 32'h40; i++) tick();
        chk("run_to_0x40", pc_out, 32'h40);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc_out, 32'h0);
        chk("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        release_and_boot();

        // 2: jump
        do_branch(32'h1000_0010);
        chk("br_to_1000_0010", pc_out, 32'h1000_0010);
        jump_valid  = 1'b1;
        jump_offset = 26'h4;
        jump_pc4    = 32'h1000_0014;
        tick();
        jump_valid = 1'b0;
        chk("jump_pc", pc_out, 32'h1000_0010);
        chk("jump_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd2);
        tick();
        chk("jump_flush_gone", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        chk("jump_seq", pc_out, 32'h1000_0014);

        // 3: simultaneous branch and jump
        jump_valid  = 1'b1;
        jump_offset = 26'h3FF;
        jump_pc4    = 32'h2000_0000;
        do_branch(32'h200);
        jump_valid = 1'b0;
        chk("simul_pc", pc_out, 32'h200);
        chk("simul_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        tick();
        chk("simul_seq", pc_out, 32'h204);

        // 4: branch during a 3-cycle stall
        held     = pc_out;
        stall_in = 1'b1;
        do_branch(32'h300);
        chk("stall_hold_c2", pc_out, held);
        chk("stall_pend_c2", {31'd0, redirect_pend}, 32'd1);
        chk("stall_noflush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        tick();
        chk("stall_hold_c3", pc_out, held);
        chk("stall_pend_c3", {31'd0, redirect_pend}, 32'd1);
        tick();
        stall_in = 1'b0;
        tick();
        chk("stall_apply", pc_out, 32'h300);
        chk("stall_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        chk("stall_pend_clr", {31'd0, redirect_pend}, 32'd0);

        // 5a: pending jump overwritten by branch
        stall_in    = 1'b1;
        jump_valid  = 1'b1;
        jump_offset = 26'h123;
        jump_pc4    = 32'h0;
        tick();
        jump_valid = 1'b0;
        do_branch(32'h500);
        stall_in = 1'b0;
        tick();
        chk("prio_j_then_br", pc_out, 32'h500);
        chk("prio_j_then_br_fl", {30'd0, flush_if_id, flush_id_ex}, 32'd3);

        // 5b: pending branch kept over a later jump
        stall_in = 1'b1;
        do_branch(32'h500);
        jump_valid  = 1'b1;
        jump_offset = 26'h77;
        tick();
        jump_valid = 1'b0;
        stall_in   = 1'b0;
        tick();
        chk("prio_br_then_j", pc_out, 32'h500);
        chk("prio_br_then_j_fl", {30'd0, flush_if_id, flush_id_ex}, 32'd3);

        // 6: wrap-around
        do_branch(32'hFFFF_FFFC);
        chk("wrap_pre", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pre_p4", pc_plus4_out, 32'h0);
        tick();
        chk("wrap_pc", pc_out, 32'h0);
        chk("wrap_p4", pc_plus4_out, 32'h4);

        // Randomized run, including unaligned branch targets and async resets
        for (int i = 0; i < 3000; i++) begin
            rst           = 1'b0;
            stall_in      = ($urandom_range(99) < 35);
            branch_valid  = ($urandom_range(99) < 15);
            branch_target = $urandom;
            jump_valid    = ($urandom_range(99) < 20);
            jump_offset   = 26'($urandom);
            jump_pc4      = $urandom;
            if ($urandom_range(199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rand_async_rst", pc_out, 32'h0);
            end
            tick();
        end

        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
